silife_grid: RTL
================

Name: silife_grid

Overview:
- Parametrised Game of Life engine, successor to the fixed silife core.
- Holds a WIDTH x HEIGHT cell array and advances one generation per update, in single-step or timed free-run mode.
- Edge handling is selectable at runtime: torus (wrap) or dead boundary.
- Host side has row write/read ports, a generation counter and empty/stable status; sits beneath the IO/display wrapper.

Parameters:
WIDTH, 8, columns per row (>=3)
HEIGHT, 8, number of rows (>=3)
GEN_W, 16, generation counter width
IV_W, 16, run-interval counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  free-run enable
step  in  1  single-generation request (ignored while en=1)
interval  in  IV_W  idle cycles between free-run updates
wrap  in  1  1 = torus edges, 0 = dead boundary
clear  in  1  synchronous clear of grid and gen_count
wr_en  in  1  row write strobe
wr_row  in  clog2(HEIGHT)  row written
wr_data  in  WIDTH  row contents, bit i = column i
rd_row  in  clog2(HEIGHT)  row read
rd_data  out  WIDTH  registered row contents
gen_count  out  GEN_W  generations computed since reset/clear
empty  out  1  all cells dead
stable  out  1  next generation equals current grid

Behaviour:
- Reset (async, reset=1): grid=0, rd_data=0, gen_count=0, interval counter=0, pending=0. empty=1 and stable=1 follow from the all-dead grid.
- Rules: live cell survives with 2 or 3 live neighbours; dead cell is born with exactly 3; otherwise dead.
- Neighbourhood:
  - wrap=1: row/column indices taken modulo HEIGHT/WIDTH.
  - wrap=0: neighbours outside the grid count as dead.
- Update: whole grid replaced by its next generation on one clock edge. gen_count increments by 1 on the same edge and wraps at 2^GEN_W.
- Update is "due" when either:
  - en=0 and step=1 on that edge; or
  - en=1 and the interval counter equals interval.
- Free-run interval counter:
  - Counts 0..interval and returns to 0 when an update is due.
  - interval=0 gives an update every cycle; interval=N gives updates every N+1 cycles.
  - Held at 0 while en=0.
  - A change of interval takes effect from the next comparison.
- Priority per edge: clear > wr_en > update.
  - clear: grid=0, gen_count=0, counter=0, pending=0.
  - wr_en with an in-range row: row written. If an update was due that cycle, it is not performed; pending is set instead.
  - Pending update: executes on the first subsequent edge without clear or wr_en, whatever en/step are. It does not double-count with a new due update on that edge: one generation only.
- Out-of-range rows (HEIGHT not a power of 2): writes are ignored; reads return 0.
- rd_data <= grid[rd_row] every edge, one-cycle latency. It shows the grid before that edge's update/write.
- empty and stable are combinational from the grid register: stable = (next == grid).
- Stable still-lifes keep incrementing gen_count while running.
- Reset asserted mid-run aborts immediately to reset state; no partial generation.

Decomposition:
- Package silife_pkg:
  - rule constants BIRTH_N=3, SURVIVE_LO=2, SURVIVE_HI=3;
  - function count_neighbours;
  - default WIDTH/HEIGHT/GEN_W/IV_W.
- Sub-module silife_cell: one state bit, eight neighbour inputs, load/load_val, update strobe, clear; exposes state and next.
- silife_grid instantiates WIDTH x HEIGHT cells via generate. It owns the wrap muxing, interval counter, pending flag, gen_count, read register and status reduction.

Test Plan:
1. Blinker, 8x8, wrap=0: write row3=8'b0001_1100, step. Rows 2,3,4 become 8'b0000_1000 and gen_count=1. Step again: original pattern restored, gen_count=2, stable=0.
2. Wrap blinker: row3 bits {7,0,1} set.
   - wrap=1, step: rows 2,3,4 = 8'b0000_0001.
   - wrap=0 (after reload), two steps: empty=1.
3. Glider, 8x8, wrap=1, en=1, interval=0: after 32 cycles grid equals initial pattern and gen_count=32.
4. Interval: en=1, interval=3 from reset with a block loaded. gen_count increments exactly at cycles 4, 8 and 12. stable=1 throughout.
5. Collision: update due on the same edge as wr_en to row 0. The row is written, gen_count is unchanged, and the update lands on the next edge with gen_count+1 once.
6. Reset mid-run: assert reset asynchronously between edges during free-run. Outputs zero immediately and empty=1. clear on a populated grid zeroes grid and gen_count on the next edge.

Source files
------------

// File: rtl/silife_pkg.sv
// Shared Game of Life rule constants, default geometry and neighbour counting.
package silife_pkg;

  localparam logic [3:0] BIRTH_N    = 4'd3;
  localparam logic [3:0] SURVIVE_LO = 4'd2;
  localparam logic [3:0] SURVIVE_HI = 4'd3;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_HEIGHT = 8;
  localparam int DEF_GEN_W  = 16;
  localparam int DEF_IV_W   = 16;

  function automatic logic [3:0] count_neighbours(input logic [7:0] nb);
    logic [3:0] sum;
    sum = 4'd0;
    for (int k = 0; k < 8; k++) begin
      sum = sum + {3'b000, nb[k]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/silife_cell.sv
// Single Life cell: holds one state bit and computes its next state from eight neighbours.
module silife_cell
  import silife_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic       i_load_val,
  input  logic       i_update,
  input  logic [7:0] i_nb,
  output logic       o_state,
  output logic       o_next
);

  logic       r_state;
  logic [3:0] w_count;

  assign w_count = count_neighbours(i_nb);
  assign o_next  = r_state ? ((w_count >= SURVIVE_LO) && (w_count <= SURVIVE_HI))
                           : (w_count == BIRTH_N);
  assign o_state = r_state;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= 1'b0;
    end else if (i_clear) begin
      r_state <= 1'b0;
    end else if (i_load) begin
      r_state <= i_load_val;
    end else if (i_update) begin
      r_state <= o_next;
    end
  end

endmodule

// File: rtl/silife_grid.sv
// WIDTH x HEIGHT Game of Life engine with step/free-run control, row host ports and status.
module silife_grid
  import silife_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int GEN_W  = DEF_GEN_W,
  parameter int IV_W   = DEF_IV_W
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_en,
  input  logic                      i_step,
  input  logic [IV_W-1:0]           i_interval,
  input  logic                      i_wrap,
  input  logic                      i_clear,
  input  logic                      i_wr_en,
  input  logic [$clog2(HEIGHT)-1:0] i_wr_row,
  input  logic [WIDTH-1:0]          i_wr_data,
  input  logic [$clog2(HEIGHT)-1:0] i_rd_row,
  output logic [WIDTH-1:0]          o_rd_data,
  output logic [GEN_W-1:0]          o_gen_count,
  output logic                      o_empty,
  output logic                      o_stable
);

  localparam int RW = $clog2(HEIGHT);

  logic [WIDTH-1:0] w_grid [HEIGHT];
  logic [WIDTH-1:0] w_next [HEIGHT];
  logic [IV_W-1:0]  r_iv;
  logic [GEN_W-1:0] r_gen;
  logic [WIDTH-1:0] r_rd;
  logic             r_pending;
  logic             w_due;
  logic             w_update;
  logic             w_rd_ok;

  // A write always wins over an update; a blocked update is remembered in r_pending.
  assign w_due    = i_en ? (r_iv == i_interval) : i_step;
  assign w_update = !i_clear && !i_wr_en && (w_due || r_pending);
  assign w_rd_ok  = (int'(i_rd_row) < HEIGHT);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_iv      <= '0;
      r_gen     <= '0;
      r_pending <= 1'b0;
      r_rd      <= '0;
    end else begin
      r_rd <= w_rd_ok ? w_grid[i_rd_row] : '0;
      if (i_clear) begin
        r_iv      <= '0;
        r_gen     <= '0;
        r_pending <= 1'b0;
      end else begin
        if (!i_en || (r_iv == i_interval)) r_iv <= '0;
        else                               r_iv <= r_iv + 1'b1;
        if (i_wr_en) r_pending <= r_pending || w_due;
        else         r_pending <= 1'b0;
        if (w_update) r_gen <= r_gen + 1'b1;
      end
    end
  end

  assign o_rd_data   = r_rd;
  assign o_gen_count = r_gen;

  genvar gi, gj;
  generate
    for (gi = 0; gi < HEIGHT; gi++) begin : g_row
      localparam int RU = (gi == 0) ? HEIGHT - 1 : gi - 1;
      localparam int RD = (gi == HEIGHT - 1) ? 0 : gi + 1;
      localparam logic [RW-1:0] ROW_ID = RW'(gi);
      logic w_ok_u, w_ok_d, w_row_load;
      // On a dead boundary the wrapped-around neighbours are masked off.
      assign w_ok_u     = i_wrap || (gi != 0);
      assign w_ok_d     = i_wrap || (gi != HEIGHT - 1);
      assign w_row_load = i_wr_en && (i_wr_row == ROW_ID);
      for (gj = 0; gj < WIDTH; gj++) begin : g_col
        localparam int CL = (gj == 0) ? WIDTH - 1 : gj - 1;
        localparam int CR = (gj == WIDTH - 1) ? 0 : gj + 1;
        logic w_ok_l, w_ok_r;
        logic [7:0] w_nb;
        assign w_ok_l = i_wrap || (gj != 0);
        assign w_ok_r = i_wrap || (gj != WIDTH - 1);
        assign w_nb = {w_grid[RU][CL] & w_ok_u & w_ok_l,
                       w_grid[RU][gj] & w_ok_u,
                       w_grid[RU][CR] & w_ok_u & w_ok_r,
                       w_grid[gi][CL] & w_ok_l,
                       w_grid[gi][CR] & w_ok_r,
                       w_grid[RD][CL] & w_ok_d & w_ok_l,
                       w_grid[RD][gj] & w_ok_d,
                       w_grid[RD][CR] & w_ok_d & w_ok_r};
        silife_cell u_cell (
          .i_clk      (i_clk),
          .i_reset    (i_reset),
          .i_clear    (i_clear),
          .i_load     (w_row_load),
          .i_load_val (i_wr_data[gj]),
          .i_update   (w_update),
          .i_nb       (w_nb),
          .o_state    (w_grid[gi][gj]),
          .o_next     (w_next[gi][gj])
        );
      end
    end
  endgenerate

  always_comb begin
    o_empty  = 1'b1;
    o_stable = 1'b1;
    for (int r = 0; r < HEIGHT; r++) begin
      if (w_grid[r] != '0)        o_empty  = 1'b0;
      if (w_next[r] != w_grid[r]) o_stable = 1'b0;
    end
  end

endmodule
